isqrt_pipe: RTL and testbench
=============================

# isqrt_pipe

Pipelined 32-bit unsigned integer square root: y = floor(sqrt(x)). It is the single isqrt instance placed beside the formula FSMs in the `*_pipe_aware_fsm_top` wrappers. It consumes `isqrt_x_vld`/`isqrt_x` and returns `isqrt_y_vld`/`isqrt_y`. It accepts one argument per cycle with a fixed latency, so an FSM can issue a, b and c on consecutive cycles.

## Interface
- `n_pipe_stages`, default 16: number of register stages; legal values are 1, 2, 4, 8, 16. Each stage performs 16 / `n_pipe_stages` iterations.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `x_vld`  in  1  argument valid, single-cycle qualifier
- `x`  in  32  unsigned radicand
- `y_vld`  out  1  result valid, exactly one pulse per accepted argument
- `y`  out  16  floor(sqrt(x)); undefined (don't-care) when `y_vld` = 0

## Operation
- Algorithm: digit-by-digit restoring square root, 16 iterations, i = 15 down to 0. State per iteration is remainder r (32 b) and root q (16 b). Initial values: r = x, q = 0.
- Iteration i:
  - t = (q << (i+1)) + (1 << 2i), computed 33 b wide, no truncation.
  - If r >= t: r -= t and q |= (1 << i). Otherwise r and q are unchanged.
- Final q is `y`. Final r is discarded.
- Stage k (0-based) executes iterations 15 − k·m down to 16 − (k+1)·m, where m = 16 / `n_pipe_stages`. Each stage is combinational over its m iterations, then registers r, q and vld.
- Valid chain: `vld[0]` <= `x_vld`; `vld[k+1]` <= `vld[k]`; `y_vld` = last `vld`.
- No backpressure and no ready signal. The block never stalls.
- Bubbles in `x_vld` propagate unchanged. Results leave in issue order.
- Data registers are not reset and are not gated by vld (they may load garbage on bubbles). Only the vld chain is reset.
- `x` is sampled only on cycles where `x_vld` = 1. The value on other cycles has no effect on any valid result.

## Timing
- Argument accepted on the rising edge at cycle t produces `y_vld` = 1 with `y` valid during cycle t + `n_pipe_stages`. Latency is exactly `n_pipe_stages` cycles.
- Throughput: 1 result per cycle. Back-to-back `x_vld` for L cycles yields L consecutive `y_vld` cycles, shifted by the latency.
- Reset: `y_vld` = 0 from the first cycle after `rst` is sampled high. All in-flight arguments are dropped and none appear after reset release.
- `x_vld` asserted in the same cycle `rst` is high is ignored.
- First valid input after reset release: normal latency, no warm-up.
- `y` is not reset. It is don't-care while `y_vld` = 0.
- Boundaries:
  - x = 0 gives y = 0.
  - x = 0xFFFF_FFFF gives y = 0xFFFF (65535). There is no overflow in t because it is computed 33 b wide.
  - Perfect squares give the exact root. Perfect square minus 1 gives root − 1.

## Structure
- `isqrt_pkg`: `isqrt_x_w` = 32, `isqrt_y_w` = 16, `isqrt_iters` = 16. It also holds the elaboration check that `n_pipe_stages` is in {1, 2, 4, 8, 16}; an illegal value is a `$fatal`.
- Sub-module `isqrt_slice`:
  - Parameters: `first_iter`, `n_iters`.
  - Purely combinational. Inputs r and q; outputs r and q after its iterations.
  - `isqrt_pipe` instantiates one slice per stage with a generate loop and owns all registers, including the vld chain.
- The formula FSMs consume exactly this port set; the top-level wrappers rename the ports to `isqrt_*`.

## Test plan
- Single shots at `n_pipe_stages` = 16, each followed by idle cycles:
  - x = 0 → 0
  - x = 1 → 1
  - x = 15 → 3
  - x = 16 → 4
  - x = 1_000_000 → 1000
  - x = 0xFFFF_FFFF → 65535
  - Each `y_vld` pulse must arrive exactly 16 cycles after its input.
- Back-to-back burst of 3 (a = 4, b = 9, c = 100, the formula_1 pattern) → `y_vld` high for 3 consecutive cycles with y = 2, 3, 10 in order.
- Random `x_vld` with about 50% bubbles, 10k random x, checked against a reference model → every result correct, `y_vld` count equals `x_vld` count, order preserved.
- Reset mid-flight: issue 5 arguments, assert `rst` for 1 cycle at cycle 8 → no `y_vld` ever appears for those 5. An argument issued after reset release returns normally 16 cycles later.
- Parameter sweep over `n_pipe_stages` ∈ {1, 2, 4, 8, 16} with x = 0xFFFF_FFFE → y = 65535 and latency equals `n_pipe_stages`.
- Garbage `x` on non-valid cycles, e.g. 0xDEAD_BEEF between valid inputs 49 and 50 → results 7 and 7 are unaffected, and no spurious `y_vld` occurs.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared widths and the pipeline-depth legality check for the pipelined
// integer square root.
package isqrt_pkg;

    localparam int isqrt_x_w   = 32;
    localparam int isqrt_y_w   = 16;
    localparam int isqrt_iters = 16;

    // Depth must divide the iteration count evenly and be a power of two.
    function automatic bit isqrt_stages_legal(input int n);
        bit ok;
        ok = 1'b0;
        if (n == 1 || n == 2 || n == 4 || n == 8 || n == 16) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/isqrt_slice.sv
// Combinational block of restoring square-root iterations, from first_iter
// down to first_iter - n_iters + 1.
module isqrt_slice
    import isqrt_pkg::*;
#(
    parameter int first_iter = 15,
    parameter int n_iters    = 1
) (
    input  logic [isqrt_x_w-1:0] r_i,
    input  logic [isqrt_y_w-1:0] q_i,
    output logic [isqrt_x_w-1:0] r_o,
    output logic [isqrt_y_w-1:0] q_o
);

    logic [isqrt_x_w:0] t_s;

    // Trial subtraction per iteration; t is one bit wider than r so it never wraps.
    always_comb begin
        r_o = r_i;
        q_o = q_i;
        t_s = '0;
        for (int j = 0; j < n_iters; j++) begin
            t_s = ({{(isqrt_x_w + 1 - isqrt_y_w){1'b0}}, q_o} << (first_iter - j + 1))
                + ((isqrt_x_w + 1)'(1) << (2 * (first_iter - j)));
            if ({1'b0, r_o} >= t_s) begin
                r_o = r_o - t_s[isqrt_x_w-1:0];
                q_o = q_o | (isqrt_y_w'(1) << (first_iter - j));
            end else begin
                r_o = r_o;
                q_o = q_o;
            end
        end
    end

endmodule

// File: rtl/isqrt_pipe.sv
// Pipelined 32-bit unsigned floor(sqrt(x)): one argument per cycle, fixed
// latency of n_pipe_stages cycles, no backpressure.
module isqrt_pipe
    import isqrt_pkg::*;
#(
    parameter int n_pipe_stages = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_vld,
    input  logic [isqrt_x_w-1:0] x,
    output logic                 y_vld,
    output logic [isqrt_y_w-1:0] y
);

    localparam int m = isqrt_iters / n_pipe_stages;

    if (!isqrt_stages_legal(n_pipe_stages)) begin : g_bad_depth
        $fatal(1, "isqrt_pipe: n_pipe_stages must be 1, 2, 4, 8 or 16");
    end

    logic [isqrt_x_w-1:0]     r_in_s [n_pipe_stages];
    logic [isqrt_y_w-1:0]     q_in_s [n_pipe_stages];
    logic [isqrt_x_w-1:0]     r_d    [n_pipe_stages];
    logic [isqrt_y_w-1:0]     q_d    [n_pipe_stages];
    logic [isqrt_x_w-1:0]     r_q    [n_pipe_stages];
    logic [isqrt_y_w-1:0]     q_q    [n_pipe_stages];
    logic [n_pipe_stages-1:0] vld_d;
    logic [n_pipe_stages-1:0] vld_q;

    for (genvar k = 0; k < n_pipe_stages; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign r_in_s[k] = x;
            assign q_in_s[k] = '0;
        end else begin : g_src
            assign r_in_s[k] = r_q[k-1];
            assign q_in_s[k] = q_q[k-1];
        end

        isqrt_slice #(
            .first_iter (isqrt_iters - 1 - k * m),
            .n_iters    (m)
        ) u_slice (
            .r_i (r_in_s[k]),
            .q_i (q_in_s[k]),
            .r_o (r_d[k]),
            .q_o (q_d[k])
        );
    end

    // Valid chain next state: shift in the new qualifier at stage 0.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = x_vld;
        for (int k = 1; k < n_pipe_stages; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    // Valid chain register; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Data registers load every cycle, bubbles included; only vld qualifies them.
    always_ff @(posedge clk) begin
        for (int k = 0; k < n_pipe_stages; k++) begin
            r_q[k] <= r_d[k];
            q_q[k] <= q_d[k];
        end
    end

    assign y_vld = vld_q[n_pipe_stages-1];
    assign y     = q_q[n_pipe_stages-1];

endmodule

// File: tb/tb_isqrt_pipe.sv
// Drives one stimulus stream into isqrt_pipe at every legal depth and checks
// each output every cycle against an arithmetic model of floor(sqrt(x)).
module tb_isqrt_pipe;

    localparam int HN = 16384;

    bit          clk = 1'b1;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic [4:0]  yv;
    logic [15:0] yy [5];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int cur_exp  = -1;
    int issued   = 0;
    int pulses16 = 0;

    logic        h_rst [HN];
    logic        h_vld [HN];
    logic [31:0] h_x   [HN];
    int          h_exp [HN];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        isqrt_pipe #(.n_pipe_stages(1 << g)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .x_vld (x_vld),
            .x     (x),
            .y_vld (yv[g]),
            .y     (yy[g])
        );
    end

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Largest y with y*y <= v, by binary search over the whole 16-bit range.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        longint lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(v)) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    // Record this cycle's inputs, then check every depth against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc < HN) begin
                h_rst[cyc] = rst;
                h_vld[cyc] = x_vld;
                h_x[cyc]   = x;
                h_exp[cyc] = cur_exp;
                if (!rst && x_vld) issued++;
                if (cyc >= 1) begin
                    for (int g = 0; g < 5; g++) begin
                        int          n, s;
                        logic        ev;
                        logic [15:0] ey, lit;
                        n  = 1 << g;
                        s  = cyc - n;
                        ev = 1'b0;
                        if (s >= 0) begin
                            ev = h_vld[s];
                            for (int d = s; d < cyc; d++) begin
                                if (h_rst[d]) ev = 1'b0;
                            end
                        end
                        checks++;
                        if (yv[g] !== ev) begin
                            failures++;
                            $display("FAIL y_vld n=%0d cyc=%0d got=%b want=%b", n, cyc, yv[g], ev);
                        end else if (ev) begin
                            ey = ref_sqrt(h_x[s]);
                            checks++;
                            if (yy[g] !== ey) begin
                                failures++;
                                $display("FAIL y_model n=%0d cyc=%0d x=%h got=%0d want=%0d",
                                         n, cyc, h_x[s], yy[g], ey);
                            end
                            if (h_exp[s] >= 0) begin
                                lit = 16'(h_exp[s]);
                                checks++;
                                if (yy[g] !== lit) begin
                                    failures++;
                                    $display("FAIL y_literal n=%0d cyc=%0d x=%h got=%0d want=%0d",
                                             n, cyc, h_x[s], yy[g], lit);
                                end
                            end
                        end
                        if (g == 4 && yv[g] === 1'b1) pulses16++;
                    end
                end
            end
        end
    end

    task automatic put(input logic v, input logic [31:0] xv, input int e);
        x_vld   = v;
        x       = xv;
        cur_exp = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, $urandom(), -1);
    endtask

    logic [31:0] sx [6] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd1000000, 32'hFFFF_FFFF};
    int          se [6] = '{0, 1, 3, 4, 1000, 65535};

    initial begin
        logic [15:0] pin;
        logic [31:0] rx;
        int          rv;

        // The model itself against the hand-computed single-shot table.
        for (int i = 0; i < 6; i++) begin
            pin = ref_sqrt(sx[i]);
            checks++;
            if (pin !== 16'(se[i])) begin
                failures++;
                $display("FAIL model_pin x=%h got=%0d want=%0d", sx[i], pin, se[i]);
            end
        end

        // Reset for cycles 0..2, with a valid argument offered during reset.
        rst     = 1'b1;
        x_vld   = 1'b1;
        x       = 32'd4;
        cur_exp = 2;
        @(posedge clk);
        #1;
        x_vld   = 1'b0;
        cur_exp = -1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            put(1'b1, sx[i], se[i]);
            idle(20);
        end

        put(1'b1, 32'd4, 2);
        put(1'b1, 32'd9, 3);
        put(1'b1, 32'd100, 10);
        idle(20);

        put(1'b1, 32'd49, 7);
        put(1'b0, 32'hDEAD_BEEF, -1);
        put(1'b1, 32'd50, 7);
        idle(20);

        put(1'b1, 32'hFFFF_FFFE, 65535);
        put(1'b1, 32'hFFFE_0001, 65535);
        put(1'b1, 32'hFFFE_0000, 65534);
        put(1'b1, 32'd99, 9);
        put(1'b1, 32'd100, 10);
        idle(20);

        // Five in flight, then a one-cycle reset at relative cycle 8.
        for (int i = 0; i < 5; i++) put(1'b1, 32'd400 + 32'(i), 20);
        idle(3);
        rst = 1'b1;
        put(1'b1, 32'd81, 9);
        rst = 1'b0;
        put(1'b1, 32'd144, 12);
        idle(20);

        for (int i = 0; i < 10000; i++) begin
            rx = $urandom();
            if ($urandom_range(7, 0) == 0) begin
                rv = int'($urandom_range(65535, 1));
                rx = 32'(rv * rv) - 32'($urandom_range(1, 0));
            end
            put(1'($urandom_range(1, 0)), rx, -1);
        end
        idle(20);

        // At depth 16 exactly the five arguments hit by the mid-flight reset are lost.
        checks++;
        if (pulses16 != issued - 5) begin
            failures++;
            $display("FAIL pulse_count n=16 got=%0d want=%0d", pulses16, issued - 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
